object_draw_scheduler: RTL

OBJECT_DRAW_SCHEDULER -- requirements
Module: object_draw_scheduler

---
 rtl/object_draw_scheduler_pkg.sv | 17 +
 rtl/object_draw_scheduler_rr_picker.sv | 32 +++
 rtl/object_draw_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/object_draw_scheduler_pkg.sv
// Shared encodings and default sizing for the object draw scheduler.
package object_draw_scheduler_pkg;

  localparam int DEF_NUM_SLOTS = 12;
  localparam int DEF_NUM_ITEMS = 16;
  localparam int DEF_TIMEOUT   = 4095;
  localparam int ADDR_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_REQ,
    S_RELEASE,
    S_SCENE_DONE
  } state_e;

endpackage

// File: rtl/object_draw_scheduler_rr_picker.sv
// Rotating first-set search: lowest pending index at or above rr_ptr_i, wrapping.
module rr_picker
  import object_draw_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
  input  logic [NUM_SLOTS-1:0] pending_i,
  input  logic [ADDR_W-1:0]    rr_ptr_i,
  output logic [ADDR_W-1:0]    index_o,
  output logic                 valid_o
);

  // Walk offsets from far to near so the nearest set bit is the last one written.
  always_comb begin
    int pos;
    logic [ADDR_W-1:0] pos_idx;
    pos     = 0;
    pos_idx = '0;
    index_o = '0;
    valid_o = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      pos = int'(rr_ptr_i) + i;
      if (pos >= NUM_SLOTS) pos = pos - NUM_SLOTS;
      pos_idx = ADDR_W'(pos);
      if (pending_i[pos_idx]) begin
        index_o = pos_idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_draw_scheduler.sv
// Sequences full-scene passes and per-slot redraws onto a single object-draw
// controller using a level request / level done return-to-zero handshake.
module object_draw_scheduler
  import object_draw_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int NUM_ITEMS = DEF_NUM_ITEMS,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start_initial,
  input  logic [NUM_SLOTS-1:0] redraw_req,
  input  logic                 draw_object_done,
  output logic                 start_draw_object,
  output logic [ADDR_W-1:0]    object_location_address,
  output logic                 start_initial_module,
  output logic                 busy,
  output logic                 scene_done,
  output logic                 timeout_err
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ITEM = ADDR_W'(NUM_ITEMS - 1);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NUM_SLOTS - 1);
  localparam logic [NUM_SLOTS-1:0] ONE_SLOT = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  state_e               state_q;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [NUM_SLOTS-1:0] requeue_q, requeue_d;
  logic                 init_req_q;
  logic                 init_mode_q;
  logic                 first_q;
  logic [ADDR_W-1:0]    rr_ptr_q;
  logic [TMR_W-1:0]     timer_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 start_q, busy_q, scene_done_q, timeout_err_q;

  logic [ADDR_W-1:0]    pick_idx;
  logic                 pick_valid;
  logic                 pass_start, redraw_pick;
  logic [NUM_SLOTS-1:0] pick_mask, cur_mask;

  rr_picker #(.NUM_SLOTS(NUM_SLOTS)) u_picker (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .index_o   (pick_idx),
    .valid_o   (pick_valid)
  );

  assign pass_start  = (state_q == S_PICK) && first_q && init_req_q;
  assign redraw_pick = (state_q == S_PICK) && first_q && !init_req_q && pick_valid;
  assign pick_mask   = ONE_SLOT << pick_idx;
  assign cur_mask    = ONE_SLOT << addr_q;

  // A re-request of the slot in flight is shadowed in requeue so that a
  // scene pass starting next (which wipes pending) cannot swallow it.
  always_comb begin
    pending_d = pending_q;
    requeue_d = requeue_q;
    if (state_q == S_IDLE && !init_req_q) begin
      pending_d = pending_q | requeue_q;
      requeue_d = '0;
    end
    if (pass_start) pending_d = '0;
    else if (redraw_pick) pending_d = pending_q & ~pick_mask;
    if (!init_mode_q && (state_q == S_REQ || state_q == S_RELEASE))
      requeue_d = requeue_q | (redraw_req & cur_mask);
    pending_d = pending_d | redraw_req;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pending_q     <= '0;
      requeue_q     <= '0;
      init_req_q    <= 1'b0;
      init_mode_q   <= 1'b0;
      first_q       <= 1'b0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      addr_q        <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      scene_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      requeue_q    <= requeue_d;
      scene_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (init_req_q || (|pending_q)) begin
            state_q     <= S_PICK;
            busy_q      <= 1'b1;
            first_q     <= 1'b1;
            init_mode_q <= init_req_q;
          end
        end
        S_PICK: begin
          state_q <= S_REQ;
          first_q <= 1'b0;
          start_q <= 1'b1;
          timer_q <= TMR_W'(TIMEOUT - 1);
          if (pass_start) begin
            addr_q      <= '0;
            init_mode_q <= 1'b1;
            init_req_q  <= 1'b0;
          end else if (first_q) begin
            if (pick_valid) begin
              addr_q   <= pick_idx;
              rr_ptr_q <= (pick_idx == LAST_SLOT) ? '0 : pick_idx + ADDR_W'(1);
            end
            init_mode_q <= 1'b0;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_REQ: begin
          if (draw_object_done) begin
            state_q <= S_RELEASE;
            start_q <= 1'b0;
          end else if (timer_q == '0) begin
            state_q       <= S_RELEASE;
            start_q       <= 1'b0;
            timeout_err_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        S_RELEASE: begin
          if (!draw_object_done) begin
            if (init_mode_q && (addr_q < LAST_ITEM)) begin
              state_q <= S_PICK;
            end else if (init_mode_q) begin
              state_q      <= S_SCENE_DONE;
              init_mode_q  <= 1'b0;
              scene_done_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_SCENE_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // A request landing on the same edge that consumes the old one survives.
      if (start_initial) init_req_q <= 1'b1;
    end
  end

  assign start_draw_object       = start_q;
  assign object_location_address = addr_q;
  assign start_initial_module    = init_mode_q;
  assign busy                    = busy_q;
  assign scene_done              = scene_done_q;
  assign timeout_err             = timeout_err_q;

endmodule
